input_buffer_stream: RTL and testbench
======================================

Name: input_buffer_stream

Overview:
Parametrised successor to the on-chip input SRAM. Holds 2^ADDR_WIDTH rows of NUM_LANES x DATA_WIDTH words, written by the host with a per-lane mask. Exposes NUM_RD_PORTS independent burst-read stream engines; each engine generates strided addresses and delivers rows over a valid/ready handshake to its consumer (systolic top/left, VPU bias).

Parameters:
DATA_WIDTH, 32, bits per lane word
NUM_LANES, 16, lanes per row (array width)
ADDR_WIDTH, 10, row address bits; depth = 2^ADDR_WIDTH
NUM_RD_PORTS, 3, number of independent read stream engines

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
host_wr_en  in  1  row write strobe
host_wr_addr  in  ADDR_WIDTH  write row address
host_wr_data  in  [NUM_LANES] x DATA_WIDTH  write data, lane i = word i
host_wr_lane_mask  in  NUM_LANES  bit i=1 updates lane i
rd_start  in  [NUM_RD_PORTS] x 1  burst start pulse per port
rd_base  in  [NUM_RD_PORTS] x ADDR_WIDTH  first row address
rd_len  in  [NUM_RD_PORTS] x (ADDR_WIDTH+1)  rows in burst
rd_stride  in  [NUM_RD_PORTS] x ADDR_WIDTH  row increment per beat
rd_busy  out  [NUM_RD_PORTS] x 1  engine active
rd_valid  out  [NUM_RD_PORTS] x 1  rd_data valid
rd_ready  in  [NUM_RD_PORTS] x 1  consumer accepts beat
rd_last  out  [NUM_RD_PORTS] x 1  final beat of burst
rd_data  out  [NUM_RD_PORTS][NUM_LANES] x DATA_WIDTH  row data

Behaviour:
- Reset: all engines IDLE, skid FIFOs empty, in-flight reads dropped; rd_busy=0, rd_valid=0, rd_last=0, rd_data=0. Memory contents not reset. Reset mid-burst aborts immediately; no further beats.
- Write: when host_wr_en, lanes with mask bit 1 at host_wr_addr are updated at the edge; masked-off lanes keep their old value. Writes never stall.
- Read-during-write, same row, same cycle: the read returns OLD data (read-first). The new data is visible to reads issued the next cycle.
- Ports fully independent. Any number of ports may read the same row in the same cycle.
- Per-engine FSM: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE: rd_start=1 with rd_len!=0 latches base/len/stride. rd_busy=1 from the next cycle. rd_start with rd_len=0 is ignored.
- rd_start while busy (RUN or DRAIN) is ignored; the current burst is unaffected.
- RUN: issue one row read per cycle while (fifo_count + inflight) < 2. Address advances by stride modulo 2^ADDR_WIDTH (wraps). Go to DRAIN when the last read is issued.
- DRAIN: wait until the last beat handshakes (rd_valid & rd_ready & rd_last), then IDLE. rd_busy=0 in the cycle after that handshake.
- Memory read latency: 1 cycle. Return data enters a 2-entry skid FIFO; rd_valid/rd_data/rd_last are driven from the FIFO head.
- Latency: start sampled at edge T with FIFO empty -> rd_valid=1 in cycle T+2.
- Throughput: with rd_ready held high, 1 beat/cycle with no bubbles.
- Backpressure: rd_ready=0 holds rd_data/rd_last stable while rd_valid=1. No beat is lost or duplicated.
- rd_valid never deasserts without a handshake.
- rd_last=1 only on beat number rd_len; otherwise 0. rd_data=0 when rd_valid=0 is not required; consumers must qualify with rd_valid.
- A new start is accepted the cycle rd_busy=0 (back-to-back bursts allowed).

Test Plan:
- Mask write: write row 5 all lanes 0x11, then mask 0x0001 data 0x22 -> port0 burst base5 len1 returns lane0=0x22, lanes1-15=0x11.
- Stream: rows 0..7 contain row index; port1 base2 len4 stride1, ready=1 -> valid at T+2, beats 2,3,4,5 on consecutive cycles, last on 4th, busy falls next cycle.
- Wrap/stride: base 1020 len4 stride3 (depth 1024) -> rows 1020,1023,2,5.
- Backpressure: port2 len6, ready toggles 1,0,0,1,... -> exactly 6 beats in order, data stable while stalled, single last.
- RDW + concurrency: write row 9 to 0xAA while ports 0 and 1 issue a read of row 9 the same cycle (old value 0x55) -> both return 0x55; a subsequent burst returns 0xAA. A start while busy is ignored.
- Reset mid-burst: assert rst during beat 3 of len8 -> next cycle valid=0, busy=0, last=0. A fresh start then works normally.

Source files
------------

// File: rtl/input_buffer_stream.sv
// input_buffer_stream
//   On-chip row buffer for host-written operand data. It holds 2^ADDR_WIDTH rows.
//   Each row has NUM_LANES words of DATA_WIDTH bits. NUM_RD_PORTS independent
//   stream engines read it back as strided bursts over a valid/ready handshake.
//
// Ports
//   clk, rst            : single rising-edge clock, synchronous active-high reset
//   host_wr_en          : row write strobe (writes never stall)
//   host_wr_addr        : row being written
//   host_wr_data        : write data, lane i is word i
//   host_wr_lane_mask   : bit i set updates lane i, cleared lanes keep old data
//   rd_start            : per-port burst start pulse (honoured only when idle)
//   rd_base/len/stride  : per-port first row, beat count, row increment
//   rd_busy             : per-port engine active
//   rd_valid/ready/last : per-port beat handshake, last marks final beat
//   rd_data             : per-port row data, qualified by rd_valid
module input_buffer_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_LANES    = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_RD_PORTS = 3
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0]                                 host_wr_addr,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]                  host_wr_data,
  input  logic [NUM_LANES-1:0]                                  host_wr_lane_mask,
  input  logic [NUM_RD_PORTS-1:0]                               rd_start,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]               rd_base,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH:0]                 rd_len,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]               rd_stride,
  output logic [NUM_RD_PORTS-1:0]                               rd_busy,
  output logic [NUM_RD_PORTS-1:0]                               rd_valid,
  input  logic [NUM_RD_PORTS-1:0]                               rd_ready,
  output logic [NUM_RD_PORTS-1:0]                               rd_last,
  output logic [NUM_RD_PORTS-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] row_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} eng_state_t;

  row_t mem [DEPTH];

  // Host write port with per-lane byte-enable style masking. The storage is
  // deliberately not reset.
  always_ff @(posedge clk) begin
    if (host_wr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (host_wr_lane_mask[i]) begin
          mem[host_wr_addr][i] <= host_wr_data[i];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_eng
    eng_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH:0]   remaining;
    row_t                  fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_count;
    logic                  start_ok;
    logic                  issue;
    logic                  issue_last;
    logic                  pop;
    logic                  head_valid;

    // The synchronous memory read lands straight in the skid FIFO at the issuing
    // edge, so nothing is ever in flight between cycles. Issuing while fewer than
    // two entries are held (even if one pops the same cycle) keeps one beat per
    // cycle under continuous ready and never overflows.
    always_comb begin
      head_valid = (fifo_count != 2'd0);
      start_ok   = (state == ST_IDLE) && rd_start[p] && (rd_len[p] != '0);
      issue      = (state == ST_RUN) && (fifo_count < 2'd2);
      issue_last = issue && (remaining == LEN_ONE);
      pop        = head_valid && rd_ready[p];
    end

    // Engine next-state logic.
    always_comb begin
      state_nxt = state;
      case (state)
        ST_IDLE:  if (start_ok)                  state_nxt = ST_RUN;
        ST_RUN:   if (issue_last)                state_nxt = ST_DRAIN;
        ST_DRAIN: if (pop && fifo_last[rd_ptr])  state_nxt = ST_IDLE;
        default:                                 state_nxt = ST_IDLE;
      endcase
    end

    // Engine state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_IDLE;
      end else begin
        state <= state_nxt;
      end
    end

    // Burst bookkeeping and FIFO pointers. A reset drops every queued beat.
    always_ff @(posedge clk) begin
      if (rst) begin
        cur_addr   <= '0;
        stride_q   <= '0;
        remaining  <= '0;
        fifo_last  <= '0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
        fifo_count <= 2'd0;
      end else begin
        if (start_ok) begin
          cur_addr  <= rd_base[p];
          stride_q  <= rd_stride[p];
          remaining <= rd_len[p];
        end
        if (issue) begin
          cur_addr          <= cur_addr + stride_q;
          remaining         <= remaining - LEN_ONE;
          fifo_last[wr_ptr] <= issue_last;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        fifo_count <= fifo_count + 2'(issue) - 2'(pop);
      end
    end

    // FIFO payload. Nonblocking semantics make a same-cycle host write to the
    // same row invisible here, which gives read-first behaviour.
    always_ff @(posedge clk) begin
      if (issue) begin
        fifo_data[wr_ptr] <= mem[cur_addr];
      end
    end

    assign rd_busy[p]  = (state != ST_IDLE);
    assign rd_valid[p] = head_valid;
    assign rd_last[p]  = head_valid && fifo_last[rd_ptr];
    assign rd_data[p]  = head_valid ? fifo_data[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_input_buffer_stream.sv
// tb_input_buffer_stream
//   Directed bench for input_buffer_stream with default parameters. It covers
//   masked writes, streaming latency and throughput, address wrap with stride,
//   backpressure, read-during-write, ignored starts, and reset in mid-burst.
module tb_input_buffer_stream;

  localparam int DW = 32;
  localparam int NL = 16;
  localparam int AW = 10;
  localparam int NP = 3;

  logic                        clk;
  logic                        rst;
  logic                        host_wr_en;
  logic [AW-1:0]               host_wr_addr;
  logic [NL-1:0][DW-1:0]       host_wr_data;
  logic [NL-1:0]               host_wr_lane_mask;
  logic [NP-1:0]               rd_start;
  logic [NP-1:0][AW-1:0]       rd_base;
  logic [NP-1:0][AW:0]         rd_len;
  logic [NP-1:0][AW-1:0]       rd_stride;
  logic [NP-1:0]               rd_busy;
  logic [NP-1:0]               rd_valid;
  logic [NP-1:0]               rd_ready;
  logic [NP-1:0]               rd_last;
  logic [NP-1:0][NL-1:0][DW-1:0] rd_data;

  int vectors;
  int miscompares;

  input_buffer_stream #(
    .DATA_WIDTH(DW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_wr_en(host_wr_en),
    .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data),
    .host_wr_lane_mask(host_wr_lane_mask),
    .rd_start(rd_start),
    .rd_base(rd_base),
    .rd_len(rd_len),
    .rd_stride(rd_stride),
    .rd_busy(rd_busy),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_last(rd_last),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int addr, input logic [31:0] val, input logic [15:0] mask);
    host_wr_en        = 1'b1;
    host_wr_addr      = addr[AW-1:0];
    for (int i = 0; i < NL; i++) host_wr_data[i] = val;
    host_wr_lane_mask = mask;
    step();
    host_wr_en        = 1'b0;
  endtask

  task automatic apply_stimulus(input int p, input int base, input int len, input int stride);
    rd_start[p]  = 1'b1;
    rd_base[p]   = base[AW-1:0];
    rd_len[p]    = len[AW:0];
    rd_stride[p] = stride[AW-1:0];
    step();
    rd_start[p]  = 1'b0;
  endtask

  // Full burst with ready held high; expected row r holds value r in every lane.
  task automatic run_burst(input int p, input int base, input int len, input int stride);
    int row;
    rd_ready[p] = 1'b1;
    apply_stimulus(p, base, len, stride);
    check_output($sformatf("busy_after_start_p%0d", p), 64'(rd_busy[p]), 64'd1);
    check_output($sformatf("no_valid_T1_p%0d", p), 64'(rd_valid[p]), 64'd0);
    for (int b = 0; b < len; b++) begin
      step();
      row = (base + b * stride) % 1024;
      check_output($sformatf("valid_p%0d_b%0d", p, b), 64'(rd_valid[p]), 64'd1);
      check_output($sformatf("lane0_p%0d_b%0d", p, b), 64'(rd_data[p][0]), 64'(row));
      check_output($sformatf("lane15_p%0d_b%0d", p, b), 64'(rd_data[p][15]), 64'(row));
      check_output($sformatf("last_p%0d_b%0d", p, b), 64'(rd_last[p]), 64'(b == len - 1));
      check_output($sformatf("busy_p%0d_b%0d", p, b), 64'(rd_busy[p]), 64'd1);
    end
    step();
    check_output($sformatf("valid_end_p%0d", p), 64'(rd_valid[p]), 64'd0);
    check_output($sformatf("busy_end_p%0d", p), 64'(rd_busy[p]), 64'd0);
  endtask

  initial begin
    int beats;
    logic stalled;
    logic [3:0] pat;
    vectors           = 0;
    miscompares       = 0;
    rst               = 1'b1;
    host_wr_en        = 1'b0;
    host_wr_addr      = '0;
    host_wr_data      = '0;
    host_wr_lane_mask = '0;
    rd_start          = '0;
    rd_base           = '0;
    rd_len            = '0;
    rd_stride         = '0;
    rd_ready          = '0;

    // Reset state
    repeat (2) step();
    check_output("reset_busy", 64'(rd_busy), 64'd0);
    check_output("reset_valid", 64'(rd_valid), 64'd0);
    check_output("reset_last", 64'(rd_last), 64'd0);
    check_output("reset_data0", 64'(rd_data[0][0]), 64'd0);
    rst = 1'b0;

    // Rows hold their own index
    for (int r = 0; r < 16; r++) write_row(r, 32'(r), 16'hFFFF);
    for (int r = 1020; r < 1024; r++) write_row(r, 32'(r), 16'hFFFF);

    // Masked write on row 5
    write_row(5, 32'h11, 16'hFFFF);
    write_row(5, 32'h22, 16'h0001);
    rd_ready[0] = 1'b1;
    apply_stimulus(0, 5, 1, 1);
    check_output("mask_busy", 64'(rd_busy[0]), 64'd1);
    step();
    check_output("mask_valid", 64'(rd_valid[0]), 64'd1);
    check_output("mask_lane0", 64'(rd_data[0][0]), 64'h22);
    check_output("mask_lane1", 64'(rd_data[0][1]), 64'h11);
    check_output("mask_lane15", 64'(rd_data[0][15]), 64'h11);
    check_output("mask_last", 64'(rd_last[0]), 64'd1);
    step();
    check_output("mask_idle", 64'(rd_busy[0]), 64'd0);
    write_row(5, 32'd5, 16'hFFFF);

    // Zero-length start is ignored
    apply_stimulus(2, 0, 0, 1);
    check_output("len0_busy", 64'(rd_busy[2]), 64'd0);
    step();
    check_output("len0_valid", 64'(rd_valid[2]), 64'd0);

    // Streaming and wrap with stride
    run_burst(1, 2, 4, 1);
    run_burst(0, 1020, 4, 3);

    // Backpressure: ready pattern 1,0,0,1 repeating
    pat     = 4'b1001;
    beats   = 0;
    stalled = 1'b0;
    rd_ready[2] = 1'b1;
    apply_stimulus(2, 0, 6, 1);
    for (int cyc = 0; cyc < 40 && beats < 6; cyc++) begin
      step();
      if (stalled) check_output("bp_hold_valid", 64'(rd_valid[2]), 64'd1);
      rd_ready[2] = pat[cyc % 4];
      stalled = 1'b0;
      if (rd_valid[2]) begin
        check_output($sformatf("bp_data_b%0d", beats), 64'(rd_data[2][0]), 64'(beats));
        check_output($sformatf("bp_last_b%0d", beats), 64'(rd_last[2]), 64'(beats == 5));
        if (rd_ready[2]) beats++;
        else stalled = 1'b1;
      end
    end
    check_output("bp_beats", 64'(beats), 64'd6);
    step();
    check_output("bp_busy_end", 64'(rd_busy[2]), 64'd0);
    check_output("bp_valid_end", 64'(rd_valid[2]), 64'd0);

    // Read-during-write on row 9 from two ports, plus a start while busy
    write_row(9, 32'h55, 16'hFFFF);
    rd_ready[0] = 1'b1;
    rd_ready[1] = 1'b1;
    rd_start[0] = 1'b1; rd_base[0] = 10'd9; rd_len[0] = 11'd1; rd_stride[0] = 10'd1;
    rd_start[1] = 1'b1; rd_base[1] = 10'd9; rd_len[1] = 11'd1; rd_stride[1] = 10'd1;
    step();
    rd_start[1]       = 1'b0;
    rd_base[0]        = 10'd0;
    rd_len[0]         = 11'd3;
    host_wr_en        = 1'b1;
    host_wr_addr      = 10'd9;
    for (int i = 0; i < NL; i++) host_wr_data[i] = 32'hAA;
    host_wr_lane_mask = 16'hFFFF;
    step();
    host_wr_en  = 1'b0;
    rd_start[0] = 1'b0;
    check_output("rdw_valid0", 64'(rd_valid[0]), 64'd1);
    check_output("rdw_valid1", 64'(rd_valid[1]), 64'd1);
    check_output("rdw_data0", 64'(rd_data[0][0]), 64'h55);
    check_output("rdw_data1", 64'(rd_data[1][7]), 64'h55);
    check_output("rdw_last0", 64'(rd_last[0]), 64'd1);
    step();
    check_output("rdw_busy_end", 64'(rd_busy[1:0]), 64'd0);
    check_output("rdw_valid_end", 64'(rd_valid[1:0]), 64'd0);
    step();
    check_output("busy_start_ignored", 64'(rd_busy[0]), 64'd0);
    apply_stimulus(0, 9, 1, 1);
    step();
    check_output("rdw_new_data", 64'(rd_data[0][3]), 64'hAA);
    step();
    check_output("rdw_new_idle", 64'(rd_busy[0]), 64'd0);

    // Reset during beat 3 of an 8-beat burst
    rd_ready[1] = 1'b1;
    apply_stimulus(1, 0, 8, 1);
    repeat (3) step();
    check_output("rst_beat3_data", 64'(rd_data[1][0]), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("rst_valid", 64'(rd_valid[1]), 64'd0);
    check_output("rst_busy", 64'(rd_busy[1]), 64'd0);
    check_output("rst_last", 64'(rd_last[1]), 64'd0);
    step();
    check_output("rst_no_beat", 64'(rd_valid[1]), 64'd0);
    run_burst(1, 3, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
